// File: rtl/mod_regfile_wb_pkg.sv
// Shared definitions for the register-file write side.
//
// Contents:
//   DATA_W, NREG, ADDR_W : register width, storage register count, address width.
//   NULL_REG             : the null register address. It is never stored and always reads zero.
//   wb_entry_t           : writeback stage entry {valid, dest, data}.
//
// Configuration macro used by the users of this package: WB_BYTE_MASK_EN
package mod_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 7;
    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] NULL_REG = 3'b111;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // An invalid entry always presents the null tag with zero data.
    // The operand read muxes test the bypass first, so this keeps reads of address 7 at zero.
    localparam wb_entry_t WB_EMPTY = '{valid: 1'b0, dest: NULL_REG, data: '0};

endpackage

// File: rtl/mod_regfile_wb_merge.sv
// Byte-lane merge for partial register writes.
//
// Ports:
//   base    in  DATA_W : current register contents, supplying the disabled lanes.
//   wdata   in  DATA_W : new write data, supplying the enabled lanes.
//   byte_en in  2      : bit0 selects [7:0], bit1 selects [15:8].
//   merged  out DATA_W : the combined word.
//
// This module is instantiated only when WB_BYTE_MASK_EN is defined.
module mod_wb_merge
    import mod_pkg::*;
(
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        byte_en,
    output logic [DATA_W-1:0] merged
);

    always_comb begin
        merged[7:0]  = byte_en[0] ? wdata[7:0]  : base[7:0];
        merged[15:8] = byte_en[1] ? wdata[15:8] : base[15:8];
    end

endmodule

// File: rtl/mod_regfile_wb.sv
// Writeback pipeline stage plus seven 16-bit storage registers.
// This is the write side of the flattened general-purpose register file.
//
// Ports:
//   clk, rst        : rising-edge clock; synchronous active-high reset.
//   mem_valid       : the MEM stage holds a register-writing instruction.
//   mem_dest        : destination register of the MEM instruction.
//   mem_is_load     : 1 writes mem_load_data; 0 writes mem_alu_data.
//   mem_alu_data    : ALU result from the MEM stage.
//   mem_load_data   : data-memory read result.
//   stall           : hold the WB entry; MEM inputs are ignored.
//   flush           : drop the MEM entry being captured this cycle.
//   mem_byte_en     : per-byte write enables (only with WB_BYTE_MASK_EN).
//   raw_data_112    : packed array; register i is at bits [16i+15:16i].
//   dest_address_wb : WB-stage destination, used as the bypass tag.
//   data_wb         : WB-stage data, used as the bypass value.
//   reg_written     : sticky per-register "written since reset" flags.
//
// Optional feature macro: WB_BYTE_MASK_EN (adds byte-masked writes).
// All outputs come directly from registers.
module mod_regfile_wb
    import mod_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_valid,
    input  logic [ADDR_W-1:0]      mem_dest,
    input  logic                   mem_is_load,
    input  logic [DATA_W-1:0]      mem_alu_data,
    input  logic [DATA_W-1:0]      mem_load_data,
    input  logic                   stall,
    input  logic                   flush,
`ifdef WB_BYTE_MASK_EN
    input  logic [1:0]             mem_byte_en,
`endif
    output logic [NREG*DATA_W-1:0] raw_data_112,
    output logic [ADDR_W-1:0]      dest_address_wb,
    output logic [DATA_W-1:0]      data_wb,
    output logic [NREG-1:0]        reg_written
);

    wb_entry_t               wb_q;
    logic [NREG*DATA_W-1:0]  array_q;
    logic [NREG-1:0]         written_q;

    logic                    capture;
    logic [DATA_W-1:0]       full_data;
    logic [DATA_W-1:0]       wb_data_next;

    always_comb begin
        full_data = mem_is_load ? mem_load_data : mem_alu_data;
        capture   = mem_valid && !stall && !flush && (mem_dest < ADDR_W'(NREG));
`ifdef WB_BYTE_MASK_EN
        capture   = capture && (mem_byte_en != 2'b00);
`endif
    end

`ifdef WB_BYTE_MASK_EN
    logic [DATA_W-1:0] array_word;
    logic [DATA_W-1:0] merge_base;

    // The array lags the WB stage by one edge. A pending write to the same
    // register must therefore supply the base, not the stale array word.
    always_comb begin
        array_word = '0;
        for (int i = 0; i < NREG; i++) begin
            if (mem_dest == ADDR_W'(i)) begin
                array_word = array_q[i*DATA_W +: DATA_W];
            end
        end
        merge_base = (wb_q.valid && !flush && (wb_q.dest == mem_dest)) ? wb_q.data : array_word;
    end

    mod_wb_merge u_merge (
        .base    (merge_base),
        .wdata   (full_data),
        .byte_en (mem_byte_en),
        .merged  (wb_data_next)
    );
`else
    assign wb_data_next = full_data;
`endif

    // A valid WB entry commits on every edge. It repeats while stalled, which is harmless.
    // Flush still lets the current entry commit; it only stops the new capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q      <= WB_EMPTY;
            array_q   <= '0;
            written_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wb_q.valid && (wb_q.dest == ADDR_W'(i))) begin
                    array_q[i*DATA_W +: DATA_W] <= wb_q.data;
                    written_q[i]                <= 1'b1;
                end
            end
            if (flush) begin
                wb_q <= WB_EMPTY;
            end else if (!stall) begin
                if (capture) begin
                    wb_q <= '{valid: 1'b1, dest: mem_dest, data: wb_data_next};
                end else begin
                    wb_q <= WB_EMPTY;
                end
            end
        end
    end

    assign raw_data_112    = array_q;
    assign dest_address_wb = wb_q.dest;
    assign data_wb         = wb_q.data;
    assign reg_written     = written_q;

endmodule

// File: tb/tb_mod_regfile_wb.sv
// Directed self-checking bench for mod_regfile_wb.
// Expected values are worked out by hand for each vector.
module tb_mod_regfile_wb;

    logic          clk;
    logic          rst;
    logic          mem_valid;
    logic [2:0]    mem_dest;
    logic          mem_is_load;
    logic [15:0]   mem_alu_data;
    logic [15:0]   mem_load_data;
    logic          stall;
    logic          flush;
    logic [111:0]  raw_data_112;
    logic [2:0]    dest_address_wb;
    logic [15:0]   data_wb;
    logic [6:0]    reg_written;
`ifdef WB_BYTE_MASK_EN
    logic [1:0]    mem_byte_en;
`endif

    int testCount;
    int failCount;

    mod_regfile_wb dut (
        .clk             (clk),
        .rst             (rst),
        .mem_valid       (mem_valid),
        .mem_dest        (mem_dest),
        .mem_is_load     (mem_is_load),
        .mem_alu_data    (mem_alu_data),
        .mem_load_data   (mem_load_data),
        .stall           (stall),
        .flush           (flush),
`ifdef WB_BYTE_MASK_EN
        .mem_byte_en     (mem_byte_en),
`endif
        .raw_data_112    (raw_data_112),
        .dest_address_wb (dest_address_wb),
        .data_wb         (data_wb),
        .reg_written     (reg_written)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [111:0] actual, input logic [111:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, step past the edge, and stop 1 ns after it for sampling.
    task automatic applyStimulus(input logic r, input logic v, input logic [2:0] d, input logic ld,
                                 input logic [15:0] alu, input logic [15:0] lmem,
                                 input logic st, input logic fl);
        rst           = r;
        mem_valid     = v;
        mem_dest      = d;
        mem_is_load   = ld;
        mem_alu_data  = alu;
        mem_load_data = lmem;
        stall         = st;
        flush         = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    logic [111:0] expRaw;

    initial begin
        testCount = 0;
        failCount = 0;
`ifdef WB_BYTE_MASK_EN
        mem_byte_en = 2'b11;
`endif
        // Test 1: reset, then three idle cycles.
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (3) idle();
        checkOutput("reset_raw", raw_data_112, 112'h0);
        checkOutput("reset_dest", 112'(dest_address_wb), 112'h7);
        checkOutput("reset_data", 112'(data_wb), 112'h0);
        checkOutput("reset_written", 112'(reg_written), 112'h0);

        // Test 2: a single ALU write to reg 2 with two-edge latency to the array.
        applyStimulus(1'b0, 1'b1, 3'd2, 1'b0, 16'hA5A5, 16'h0, 1'b0, 1'b0);
        checkOutput("t2_dest", 112'(dest_address_wb), 112'h2);
        checkOutput("t2_data", 112'(data_wb), 112'hA5A5);
        checkOutput("t2_raw_not_yet", raw_data_112, 112'h0);
        idle();
        expRaw = 112'h0;
        expRaw[47:32] = 16'hA5A5;
        checkOutput("t2_raw", raw_data_112, expRaw);
        checkOutput("t2_written", 112'(reg_written), 112'h04);
        checkOutput("t2_dest_inv", 112'(dest_address_wb), 112'h7);
        checkOutput("t2_data_inv", 112'(data_wb), 112'h0);

        // Test 3: back-to-back writes to reg 5; the second write is a load.
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b0, 16'h1111, 16'h9999, 1'b0, 1'b0);
        checkOutput("t3_data1", 112'(data_wb), 112'h1111);
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b1, 16'hDEAD, 16'h2222, 1'b0, 1'b0);
        checkOutput("t3_data2", 112'(data_wb), 112'h2222);
        expRaw[95:80] = 16'h1111;
        checkOutput("t3_raw_first", raw_data_112, expRaw);
        idle();
        expRaw[95:80] = 16'h2222;
        checkOutput("t3_raw_second", raw_data_112, expRaw);
        checkOutput("t3_written", 112'(reg_written), 112'h24);

        // Test 4: a write to the null register is never captured.
        applyStimulus(1'b0, 1'b1, 3'd7, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        checkOutput("t4_dest", 112'(dest_address_wb), 112'h7);
        checkOutput("t4_data", 112'(data_wb), 112'h0);
        idle();
        checkOutput("t4_raw", raw_data_112, expRaw);
        checkOutput("t4_written", 112'(reg_written), 112'h24);

        // Test 5: capture reg 0, then stall for three cycles while MEM offers reg 1.
        applyStimulus(1'b0, 1'b1, 3'd0, 1'b0, 16'h00F0, 16'h0, 1'b0, 1'b0);
        checkOutput("t5_data0", 112'(data_wb), 112'h00F0);
        expRaw[15:0] = 16'h00F0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 16'h1234, 16'h0, 1'b1, 1'b0);
            checkOutput("t5_stall_data", 112'(data_wb), 112'h00F0);
            checkOutput("t5_stall_dest", 112'(dest_address_wb), 112'h0);
            checkOutput("t5_stall_raw", raw_data_112, expRaw);
        end
        applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 16'h1234, 16'h0, 1'b0, 1'b0);
        checkOutput("t5_resume_dest", 112'(dest_address_wb), 112'h1);
        checkOutput("t5_resume_data", 112'(data_wb), 112'h1234);
        idle();
        expRaw[31:16] = 16'h1234;
        checkOutput("t5_raw", raw_data_112, expRaw);
        checkOutput("t5_written", 112'(reg_written), 112'h27);

        // Test 6a: a flush together with MEM reg 3 while WB holds reg 4.
        applyStimulus(1'b0, 1'b1, 3'd4, 1'b0, 16'hBEEF, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd3, 1'b0, 16'h3333, 16'h0, 1'b0, 1'b1);
        expRaw[79:64] = 16'hBEEF;
        checkOutput("t6_flush_dest", 112'(dest_address_wb), 112'h7);
        checkOutput("t6_flush_data", 112'(data_wb), 112'h0);
        checkOutput("t6_flush_raw", raw_data_112, expRaw);
        idle();
        checkOutput("t6_reg3_untouched", raw_data_112, expRaw);
        checkOutput("t6_written", 112'(reg_written), 112'h37);

        // Test 6b: flush wins over stall.
        applyStimulus(1'b0, 1'b1, 3'd6, 1'b0, 16'h6666, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 16'h7777, 16'h0, 1'b1, 1'b1);
        expRaw[111:96] = 16'h6666;
        checkOutput("t6_flushstall_dest", 112'(dest_address_wb), 112'h7);
        checkOutput("t6_flushstall_raw", raw_data_112, expRaw);

        // Test 6c: reset asserted in the middle of a stall clears everything.
        applyStimulus(1'b0, 1'b1, 3'd4, 1'b0, 16'hCAFE, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd2, 1'b0, 16'h5555, 16'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'd2, 1'b0, 16'h5555, 16'h0, 1'b1, 1'b0);
        checkOutput("t6_rst_raw", raw_data_112, 112'h0);
        checkOutput("t6_rst_dest", 112'(dest_address_wb), 112'h7);
        checkOutput("t6_rst_data", 112'(data_wb), 112'h0);
        checkOutput("t6_rst_written", 112'(reg_written), 112'h0);
        idle();
        checkOutput("t6_post_rst_raw", raw_data_112, 112'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
